// File: rtl/msg_arb_pkg.sv
// Shared types and widths for the packet-granular stream arbiter.
// Used by the interface, the round-robin picker and the arbiter top.
package msg_arb_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ABORT,
        ST_DRAIN
    } arb_state_e;

endpackage

// File: rtl/msg_stream_arbiter_if.sv
// Bundle of the N upstream streams, the merged downstream stream and status.
// slave is the arbiter view, master is the environment view.
interface msg_stream_arbiter_if #(
    parameter int NUM_SRC = 4
);
    import msg_arb_pkg::*;

    localparam int TID_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]        s_tvalid;
    logic [NUM_SRC-1:0]        s_tready;
    logic [DATA_W*NUM_SRC-1:0] s_tdata;
    logic [KEEP_W*NUM_SRC-1:0] s_tkeep;
    logic [NUM_SRC-1:0]        s_tlast;
    logic [NUM_SRC-1:0]        s_tuser;

    logic              m_tvalid;
    logic              m_tready;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tlast;
    logic              m_tuser;
    logic [TID_W-1:0]  m_tid;
    logic              abort_pulse;

    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser,
        output m_tid, abort_pulse
    );

    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tlast, s_tuser, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser,
        input  m_tid, abort_pulse
    );

endinterface

// File: rtl/msg_stream_arbiter_rr_picker.sv
// Combinational N-way round-robin select; the search starts one past last.
// any is low when no request is pending (pick is then 0).
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] pick,
    output logic                 any
);

    localparam int W = $clog2(N);

    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        any  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[idx]) begin
                any  = 1'b1;
                pick = W'(idx);
            end
        end
    end

endmodule

// File: rtl/msg_stream_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC AXI streams into one.
// Define MSG_ARB_TIMEOUT_EN to build the mid-packet stall watchdog.
module msg_stream_arbiter
    import msg_arb_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    msg_stream_arbiter_if.slave  bus
);

    localparam int TID_W = $clog2(NUM_SRC);

    arb_state_e state, state_nx;

    logic [TID_W-1:0] grant;
    logic [TID_W-1:0] last_grant;
    logic [TID_W-1:0] pick;
    logic             any_req;
    logic             done;

    logic [NUM_SRC-1:0] s_rdy;
    logic               m_vld;
    logic [DATA_W-1:0]  m_dat;
    logic [KEEP_W-1:0]  m_kep;
    logic               m_lst;
    logic               m_usr;
    logic               abort;

    rr_picker #(.N(NUM_SRC)) u_pick (
        .req  (bus.s_tvalid),
        .last (last_grant),
        .pick (pick),
        .any  (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= TID_W'(NUM_SRC - 1);
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && any_req)
                grant <= pick;
            if (done)
                last_grant <= grant;
        end
    end

`ifdef MSG_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_hit;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (state != ST_BUSY || bus.s_tvalid[grant])
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + 1'b1;
    end

    // This cycle is the TIMEOUT_CYCLES-th consecutive idle one.
    assign stall_hit = (state == ST_BUSY) && !bus.s_tvalid[grant] &&
                       (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_nx = state;
        s_rdy    = '0;
        m_vld    = 1'b0;
        m_dat    = '0;
        m_kep    = '0;
        m_lst    = 1'b0;
        m_usr    = 1'b0;
        abort    = 1'b0;
        done     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (any_req)
                    state_nx = ST_BUSY;
            end
            ST_BUSY: begin
                m_vld        = bus.s_tvalid[grant];
                s_rdy[grant] = bus.m_tready;
                m_dat = bus.s_tdata[DATA_W*grant +: DATA_W];
                m_kep = bus.s_tkeep[KEEP_W*grant +: KEEP_W];
                m_lst = bus.s_tlast[grant];
                m_usr = bus.s_tuser[grant];
                if (m_vld && bus.m_tready && m_lst) begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end
`ifdef MSG_ARB_TIMEOUT_EN
                else if (stall_hit) begin
                    state_nx = ST_ABORT;
                end
`endif
            end
`ifdef MSG_ARB_TIMEOUT_EN
            ST_ABORT: begin
                m_vld = 1'b1;
                m_lst = 1'b1;
                m_usr = 1'b1;
                if (bus.m_tready) begin
                    abort    = 1'b1;
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                s_rdy[grant] = 1'b1;
                if (bus.s_tvalid[grant] && bus.s_tlast[grant]) begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
        if (rst) begin
            s_rdy = '0;
            m_vld = 1'b0;
            abort = 1'b0;
        end
    end

    assign bus.s_tready    = s_rdy;
    assign bus.m_tvalid    = m_vld;
    assign bus.m_tdata     = m_dat;
    assign bus.m_tkeep     = m_kep;
    assign bus.m_tlast     = m_lst;
    assign bus.m_tuser     = m_usr;
    assign bus.m_tid       = grant;
`ifdef MSG_ARB_TIMEOUT_EN
    assign bus.abort_pulse = abort;
`else
    assign bus.abort_pulse = 1'b0;
`endif

endmodule
